// File: rtl/sram_bus_pkg.sv
// Shared types and defaults for the asynchronous 8-bit SRAM bus initiator.
// Defaults match the emulated 32Kx8 SRM2B256SLMX parts.
package sram_bus_pkg;

   localparam int unsigned SRAM_ADDR_W     = 15;
   localparam int unsigned SRAM_DATA_W     = 8;
   localparam int unsigned DEF_SETUP_CYC   = 1;
   localparam int unsigned DEF_STROBE_CYC  = 3;
   localparam int unsigned DEF_HOLD_CYC    = 1;
   localparam int unsigned CNT_W           = 8;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StStrobe,
      StHold,
      StTurn
   } state_e;

   // Phase counters count down to zero, so a phase of N cycles loads N-1.
   function automatic logic [CNT_W-1:0] cyc_to_cnt(input int unsigned cyc);
      return CNT_W'(cyc - 1);
   endfunction

endpackage

// File: rtl/sram_io_buf.sv
// Tristate driver for the SRAM data pins, kept separate so the pin-bank and
// logic-model builds can swap the buffer without touching the sequencer.
module sram_io_buf #(
   parameter int unsigned DATA_W = 8
) (
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              oe_i,
   output logic [DATA_W-1:0] rdata_o,
   inout  wire  [DATA_W-1:0] io_io
);

   assign io_io   = oe_i ? wdata_i : {DATA_W{1'bz}};
   assign rdata_o = io_io;

endmodule

// File: rtl/sram_bus_master.sv
// Request/acknowledge host port to timed asynchronous SRAM read/write cycles,
// with registered pins, registered read data and a read-to-write turnaround.
module sram_bus_master
   import sram_bus_pkg::*;
#(
   parameter int unsigned ADDR_W     = SRAM_ADDR_W,
   parameter int unsigned DATA_W     = SRAM_DATA_W,
   parameter int unsigned SETUP_CYC  = DEF_SETUP_CYC,
   parameter int unsigned STROBE_CYC = DEF_STROBE_CYC,
   parameter int unsigned HOLD_CYC   = DEF_HOLD_CYC
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              REQ,
   input  logic              WR,
   input  logic [ADDR_W-1:0] ADDR,
   input  logic [DATA_W-1:0] WDATA,
   output logic              READY,
   output logic [DATA_W-1:0] RDATA,
   output logic              RVALID,
   output logic              DONE,
   output logic [ADDR_W-1:0] A,
   output logic              nCS,
   output logic              nOE,
   output logic              nWE,
   inout  wire  [DATA_W-1:0] IO
);

   localparam logic [CNT_W-1:0] SetupLoad  = cyc_to_cnt(SETUP_CYC);
   localparam logic [CNT_W-1:0] StrobeLoad = cyc_to_cnt(STROBE_CYC);
   localparam logic [CNT_W-1:0] HoldLoad   = cyc_to_cnt(HOLD_CYC);

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                ready_q;
   logic [ADDR_W-1:0]   a_q;
   logic                ncs_q;
   logic                noe_q;
   logic                nwe_q;
   logic                io_oe_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                rd_last_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                rvalid_q;
   logic                done_q;
   logic [DATA_W-1:0]   io_rd;

   sram_io_buf #(
      .DATA_W (DATA_W)
   ) u_io_buf (
      .wdata_i (wdata_q),
      .oe_i    (io_oe_q),
      .rdata_o (io_rd),
      .io_io   (IO)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         ready_q   <= 1'b1;
         a_q       <= '0;
         ncs_q     <= 1'b1;
         noe_q     <= 1'b1;
         nwe_q     <= 1'b1;
         io_oe_q   <= 1'b0;
         wdata_q   <= '0;
         rd_last_q <= 1'b0;
         rdata_q   <= '0;
         rvalid_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         rvalid_q <= 1'b0;
         done_q   <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (REQ) begin
                  a_q       <= ADDR;
                  wdata_q   <= WDATA;
                  rd_last_q <= ~WR;
                  io_oe_q   <= WR;
                  ncs_q     <= 1'b0;
                  ready_q   <= 1'b0;
                  cnt_q     <= SetupLoad;
                  state_q   <= StSetup;
               end
            end
            StSetup: begin
               if (cnt_q == '0) begin
                  noe_q   <= ~rd_last_q;
                  nwe_q   <= rd_last_q;
                  cnt_q   <= StrobeLoad;
                  state_q <= StStrobe;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StStrobe: begin
               if (cnt_q == '0) begin
                  // Sample while nOE is still low so the SRAM is still driving.
                  if (rd_last_q) begin
                     rdata_q  <= io_rd;
                     rvalid_q <= 1'b1;
                  end
                  noe_q   <= 1'b1;
                  nwe_q   <= 1'b1;
                  cnt_q   <= HoldLoad;
                  state_q <= StHold;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StHold: begin
               if (cnt_q == '0) begin
                  ncs_q   <= 1'b1;
                  io_oe_q <= 1'b0;
                  done_q  <= 1'b1;
                  if (rd_last_q) begin
                     state_q <= StTurn;
                  end else begin
                     ready_q <= 1'b1;
                     state_q <= StIdle;
                  end
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            StTurn: begin
               ready_q <= 1'b1;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign READY  = ready_q;
   assign RDATA  = rdata_q;
   assign RVALID = rvalid_q;
   assign DONE   = done_q;
   assign A      = a_q;
   assign nCS    = ncs_q;
   assign nOE    = noe_q;
   assign nWE    = nwe_q;

endmodule

// File: tb/tb_sram_bus_master.sv
// Bench for sram_bus_master: default-timing and custom-timing instances, each
// on a behavioural SRAM, checked cycle by cycle against spec-derived timing.
module tb_sram_bus_master;

   logic        clk = 1'b0;
   logic        nrst;
   logic        req1, req2, wr;
   logic [14:0] addr;
   logic [7:0]  wdata;

   logic        ready1, rvalid1, done1, ncs1, noe1, nwe1;
   logic [7:0]  rdata1;
   logic [14:0] a1;
   wire  [7:0]  io1;
   logic        ready2, rvalid2, done2, ncs2, noe2, nwe2;
   logic [7:0]  rdata2;
   logic [14:0] a2;
   wire  [7:0]  io2;

   int total = 0;
   int bad = 0;
   int done_cnt1 = 0;
   int both_low = 0;
   logic [7:0] zz;

   logic [7:0] sram    [logic [14:0]];
   logic [7:0] ref_mem [logic [14:0]];

   always #5 clk = ~clk;

   sram_bus_master u_dut1 (
      .CLK (clk), .nRST (nrst), .REQ (req1), .WR (wr), .ADDR (addr), .WDATA (wdata),
      .READY (ready1), .RDATA (rdata1), .RVALID (rvalid1), .DONE (done1),
      .A (a1), .nCS (ncs1), .nOE (noe1), .nWE (nwe1), .IO (io1)
   );

   sram_bus_master #(
      .SETUP_CYC (2), .STROBE_CYC (1), .HOLD_CYC (3)
   ) u_dut2 (
      .CLK (clk), .nRST (nrst), .REQ (req2), .WR (wr), .ADDR (addr), .WDATA (wdata),
      .READY (ready2), .RDATA (rdata2), .RVALID (rvalid2), .DONE (done2),
      .A (a2), .nCS (ncs2), .nOE (noe2), .nWE (nwe2), .IO (io2)
   );

   function automatic logic [7:0] init_byte(input logic [14:0] ad);
      return ad[7:0] ^ {1'b0, ad[14:8]} ^ 8'h5A;
   endfunction

   function automatic logic [7:0] sram_rd(input logic [14:0] ad);
      return sram.exists(ad) ? sram[ad] : init_byte(ad);
   endfunction

   function automatic logic [7:0] ref_read(input logic [14:0] ad);
      return ref_mem.exists(ad) ? ref_mem[ad] : init_byte(ad);
   endfunction

   // Behavioural SRAM: drives on nCS&nOE low, latches on the rising edge of nWE.
   assign io1 = (!ncs1 && !noe1) ? sram_rd(a1) : 8'hzz;
   assign io2 = (!ncs2 && !noe2) ? sram_rd(a2) : 8'hzz;

   always @(posedge nwe1 or posedge nwe2) begin
      if (nrst) begin
         if (!ncs1) sram[a1] = io1;
         if (!ncs2) sram[a2] = io2;
      end
   end

   always @(negedge clk) begin
      if (done1) done_cnt1 = done_cnt1 + 1;
      if ((!noe1 && !nwe1) || (!noe2 && !nwe2)) both_low = both_low + 1;
   end

   // mode 0: drop REQ after accept; 1: hold REQ high; 2: random REQ noise while busy.
   task automatic run_access(input bit sel, input bit wr_i, input logic [14:0] addr_i,
                             input logic [7:0] wd_i, input int mode);
      int s, t, h, busy, last;
      logic [7:0] exp_rd, o_io, o_rdata;
      logic [14:0] o_a;
      logic [5:0] o_v, e_v;
      bit strobe;
      s = sel ? 2 : 1;
      t = sel ? 1 : 3;
      h = sel ? 3 : 1;
      busy = s + t + h;
      last = busy + (wr_i ? 0 : 1);
      total++;
      if ((sel ? ready2 : ready1) !== 1'b1) begin
         bad++;
         $display("FAIL accept_ready sel=%0d got=%b want=1", sel, sel ? ready2 : ready1);
      end
      wr = wr_i;
      addr = addr_i;
      wdata = wd_i;
      if (sel) req2 = 1'b1;
      else req1 = 1'b1;
      exp_rd = ref_read(addr_i);
      if (wr_i) ref_mem[addr_i] = wd_i;
      for (int k = 1; k <= last + 1; k++) begin
         @(negedge clk);
         o_v = sel ? {ready2, ncs2, noe2, nwe2, rvalid2, done2}
                   : {ready1, ncs1, noe1, nwe1, rvalid1, done1};
         o_a = sel ? a2 : a1;
         o_io = sel ? io2 : io1;
         o_rdata = sel ? rdata2 : rdata1;
         strobe = (k > s) && (k <= s + t);
         e_v = {k > last, k > busy, !(strobe && !wr_i), !(strobe && wr_i),
                !wr_i && (k == s + t + 1), k == busy + 1};
         total++;
         if (o_v !== e_v) begin
            bad++;
            $display("FAIL ctl sel=%0d k=%0d rdy/ncs/noe/nwe/rv/done got=%b want=%b",
                     sel, k, o_v, e_v);
         end
         if (k <= busy) begin
            total++;
            if (o_a !== addr_i) begin
               bad++;
               $display("FAIL addr sel=%0d k=%0d got=%h want=%h", sel, k, o_a, addr_i);
            end
         end
         if (!wr_i && k == s + t + 1) begin
            total++;
            if (o_rdata !== exp_rd) begin
               bad++;
               $display("FAIL rdata sel=%0d addr=%h got=%h want=%h", sel, addr_i, o_rdata, exp_rd);
            end
         end
         total++;
         if (wr_i && k <= busy) begin
            if (o_io !== wd_i) begin
               bad++;
               $display("FAIL io_wr sel=%0d k=%0d got=%h want=%h", sel, k, o_io, wd_i);
            end
         end else if (!wr_i && strobe) begin
            if (o_io !== exp_rd) begin
               bad++;
               $display("FAIL io_rd sel=%0d k=%0d got=%h want=%h", sel, k, o_io, exp_rd);
            end
         end else if (o_io !== zz) begin
            bad++;
            $display("FAIL io_release sel=%0d k=%0d got=%h want=z", sel, k, o_io);
         end
         if (mode == 0 && k == 1) begin
            req1 = 1'b0;
            req2 = 1'b0;
            wr = 1'($urandom);
            addr = 15'($urandom);
            wdata = 8'($urandom);
         end
         if (mode == 2) begin
            if (k <= last) begin
               if (sel) req2 = 1'($urandom);
               else req1 = 1'($urandom);
               wr = 1'($urandom);
               addr = 15'($urandom);
               wdata = 8'($urandom);
            end else begin
               req1 = 1'b0;
               req2 = 1'b0;
            end
         end
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      req1 = 1'b0;
      req2 = 1'b0;
      wr = 1'b0;
      addr = '0;
      wdata = '0;
      repeat (3) @(negedge clk);
      total++;
      if ({ready1, ncs1, noe1, nwe1, rvalid1, done1} !== 6'b111100 || a1 !== 15'h0 ||
          rdata1 !== 8'h00 || io1 !== zz) begin
         bad++;
         $display("FAIL reset1 got ctl=%b a=%h rd=%h io=%h want ctl=111100 a=0 rd=0 io=z",
                  {ready1, ncs1, noe1, nwe1, rvalid1, done1}, a1, rdata1, io1);
      end
      total++;
      if ({ready2, ncs2, noe2, nwe2, rvalid2, done2} !== 6'b111100 || a2 !== 15'h0 ||
          rdata2 !== 8'h00) begin
         bad++;
         $display("FAIL reset2 got ctl=%b a=%h rd=%h want ctl=111100 a=0 rd=0",
                  {ready2, ncs2, noe2, nwe2, rvalid2, done2}, a2, rdata2);
      end
      nrst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_uninit_read();
      int d0;
      d0 = done_cnt1;
      run_access(1'b0, 1'b0, 15'h0000, 8'h00, 0);
      @(negedge clk);
      total++;
      if (done_cnt1 - d0 !== 1) begin
         bad++;
         $display("FAIL uninit_done_count got=%0d want=1", done_cnt1 - d0);
      end
   endtask

   task automatic test_write_read();
      run_access(1'b0, 1'b1, 15'h1234, 8'hA5, 0);
      run_access(1'b0, 1'b0, 15'h1234, 8'h00, 0);
   endtask

   task automatic test_back_to_back();
      int b0;
      logic [14:0] ad;
      b0 = both_low;
      for (int i = 0; i < 8; i++) begin
         ad = i[1] ? 15'h7FFF : 15'h0000;
         run_access(1'b0, i[0], ad, 8'($urandom_range(1, 255)), (i == 7) ? 0 : 1);
      end
      @(negedge clk);
      total++;
      if (both_low !== b0) begin
         bad++;
         $display("FAIL b2b_both_strobes got=%0d want=%0d", both_low, b0);
      end
   endtask

   task automatic test_timing_params();
      logic [14:0] ad;
      ad = 15'($urandom);
      run_access(1'b1, 1'b1, ad, 8'($urandom_range(1, 255)), 0);
      run_access(1'b1, 1'b0, ad, 8'h00, 0);
      run_access(1'b1, 1'b0, 15'h1234, 8'h00, 0);
   endtask

   task automatic test_ignored_req();
      int d0, n;
      d0 = done_cnt1;
      n = 6;
      for (int i = 0; i < n; i++) begin
         run_access(1'b0, 1'($urandom), 15'h0100 + 15'(i % 3), 8'($urandom_range(1, 255)), 2);
      end
      @(negedge clk);
      total++;
      if (done_cnt1 - d0 !== n) begin
         bad++;
         $display("FAIL ignored_done_count got=%0d want=%0d", done_cnt1 - d0, n);
      end
   endtask

   task automatic test_reset_mid_write();
      run_access(1'b0, 1'b1, 15'h0ABC, 8'h3C, 0);
      wr = 1'b1;
      addr = 15'h0ABC;
      wdata = 8'hC3;
      req1 = 1'b1;
      @(negedge clk);
      req1 = 1'b0;
      @(negedge clk);
      total++;
      if (nwe1 !== 1'b0) begin
         bad++;
         $display("FAIL midwr_in_strobe got nWE=%b want=0", nwe1);
      end
      #2 nrst = 1'b0;
      #1;
      total++;
      if ({ready1, ncs1, noe1, nwe1} !== 4'b1111 || io1 !== zz) begin
         bad++;
         $display("FAIL midwr_async got rdy/ncs/noe/nwe=%b io=%h want 1111 io=z",
                  {ready1, ncs1, noe1, nwe1}, io1);
      end
      @(negedge clk);
      nrst = 1'b1;
      @(negedge clk);
      run_access(1'b0, 1'b0, 15'h0ABC, 8'h00, 0);
   endtask

   task automatic test_random();
      logic [14:0] ad;
      for (int i = 0; i < 24; i++) begin
         ad = 15'h0200 + 15'($urandom_range(0, 3));
         run_access(1'($urandom), 1'($urandom), ad, 8'($urandom_range(1, 255)), 0);
      end
   endtask

   initial begin
      zz = 8'hzz;
      test_reset();
      test_uninit_read();
      test_write_read();
      test_back_to_back();
      test_timing_params();
      test_ignored_req();
      test_reset_mid_write();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sram_bus_master.md
Name: sram_bus_master

Overview:
- Initiator for the 8-bit asynchronous SRAM bus (A/nCS/nOE/nWE/IO) used by the emulated 32Kx8 SRM2B256SLMX parts.
- Converts a single-cycle request/acknowledge host interface into correctly timed SRAM read and write cycles.
- Sits between TTM4 emulator bus logic and either the logic-level SRAM model or an external SRAM pin bank.
- Read data is registered, and a bus turnaround gap is enforced.

Parameters:
- ADDR_W, 15, SRAM address width.
- DATA_W, 8, SRAM data width.
- SETUP_CYC, 1, CLK cycles of address/nCS setup before strobe (min 1).
- STROBE_CYC, 3, CLK cycles nOE/nWE held low (min 1).
- HOLD_CYC, 1, CLK cycles after strobe release before nCS high (min 1).

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- REQ  in  1  host request; sampled only while READY=1.
- WR  in  1  1=write, 0=read; sampled with REQ.
- ADDR  in  ADDR_W  host address; sampled with REQ.
- WDATA  in  DATA_W  write data; sampled with REQ.
- READY  out  1  1 when a new REQ can be accepted.
- RDATA  out  DATA_W  registered read data.
- RVALID  out  1  one-cycle pulse when RDATA is updated.
- DONE  out  1  one-cycle pulse at the end of every access (read or write).
- A  out  ADDR_W  SRAM address.
- nCS  out  1  SRAM chip select, active low.
- nOE  out  1  SRAM output enable, active low.
- nWE  out  1  SRAM write enable, active low.
- IO  inout  DATA_W  SRAM data bus; driven only during write cycles, otherwise Z.

Behaviour:
- Clock and reset: single clock CLK. Reset nRST is asynchronous and active-low.
- Reset values: state=IDLE, READY=1, nCS=1, nOE=1, nWE=1, IO=Z, A=0, RDATA=0, RVALID=0, DONE=0, rd_last=0.
- All SRAM-side outputs are registered. No combinational path from host inputs to pins.
- States: IDLE, SETUP, STROBE, HOLD, TURN. A down-counter cnt is reloaded on each state entry.
- IDLE:
  - READY=1.
  - On REQ=1: latch ADDR, WR and WDATA; A<=ADDR; nCS<=0; READY<=0; go to SETUP with cnt=SETUP_CYC-1.
  - If the accepted request is a write, drive the IO enable from SETUP entry.
- SETUP:
  - Hold A and nCS.
  - When cnt=0, go to STROBE with cnt=STROBE_CYC-1.
  - On entry to STROBE, drive nOE<=0 for a read or nWE<=0 for a write. Exactly one strobe is ever low.
- STROBE:
  - Hold the strobe for exactly STROBE_CYC cycles.
  - When cnt=0 on a read, capture IO into RDATA and pulse RVALID for one cycle.
  - When cnt=0, release the strobe (nOE/nWE<=1) and go to HOLD with cnt=HOLD_CYC-1.
- HOLD:
  - A, nCS and the write data stay stable.
  - When cnt=0: nCS<=1; IO released to Z; DONE pulses for one cycle.
  - If the access was a read, go to TURN. Otherwise go to IDLE.
- TURN:
  - Lasts one cycle with READY=0, then go to IDLE.
  - This guarantees at least one idle cycle with nOE high before any following write drives IO.
- Throughput:
  - Write: READY low for SETUP_CYC+STROBE_CYC+HOLD_CYC cycles after the accept edge.
  - Read: the same plus 1 cycle.
  - Defaults: write = 5 cycles, read = 6 cycles, REQ to RVALID = 4 cycles.
- REQ while READY=0 is ignored (not queued). Host inputs may change freely after acceptance.
- Back-to-back REQ held high: a new request is accepted on the first IDLE cycle, so nCS is high for at least one cycle between accesses.
- Reset mid-access: all outputs return immediately to reset values (strobes high, IO=Z). The partial write is not completed.
- Address wrap: none. A is the latched ADDR unmodified.

Decomposition:
- Shared package sram_bus_pkg holds:
  - state enum (IDLE, SETUP, STROBE, HOLD, TURN);
  - default timing constants;
  - ADDR_W/DATA_W defaults matching the SRAM model.
- One natural sub-module, sram_io_buf: tristate driver for IO (wdata, oe) returning the sampled input. It keeps the tristate inference isolated for the FPGA pin vs. logic-model builds.

Test Plan:
1. Write then read at the same address: write A=0x1234 D=0xA5, then read A=0x1234 -> nWE low exactly 3 cycles; RDATA=0xA5 with RVALID 4 cycles after the read accept; nOE never low during the write.
2. Back-to-back REQ held high with alternating R/W on addresses 0x0000 and 0x7FFF -> nCS high at least 1 cycle between accesses; IO=Z during the TURN cycle after every read; no cycle with nOE=0 and IO driven.
3. Timing parameters SETUP_CYC=2, STROBE_CYC=1, HOLD_CYC=3 -> strobe width 1, A stable from 2 cycles before until 3 cycles after the strobe; write READY low for 6 cycles.
4. REQ pulses while READY=0 -> ignored; the response matches the single accepted access, and DONE count equals the accept count.
5. nRST asserted in the middle of STROBE of a write -> nWE/nCS/nOE go to 1 and IO=Z without waiting for CLK; READY=1 after release; the next read returns the model's prior content.
6. Read from uninitialised 0x0000 after reset -> A=0x0000, RVALID pulses once, DONE pulses once, and the state returns to IDLE.
